dec256_key_sched: RTL and testbench
===================================

# dec256_key_sched

Sequential AES-256 round-key scheduler that sits directly upstream of the AES-256 decryption datapath. It accepts a 256-bit cipher key over a valid/ready handshake. It then expands the key iteratively with one shared `key_expansion_256` instance, one expansion step per clock, and stores all 15 round keys. Once expansion finishes, it serves round keys through a registered, index-addressed read port in decryption order (index 0 = first key applied to ciphertext). This replaces seven unrolled combinational expansion stages with one stage and a 15-entry register file.

## Interface
- No parameters; widths are fixed by AES-256.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `key`  input  256  cipher key; `key[255:128]` is the first round key of encryption.
- `key_valid`  input  1  a key is offered; it is accepted on a cycle where `key_valid && key_ready`.
- `key_ready`  output  1  high in IDLE and READY, low in EXPAND.
- `keys_valid`  output  1  high in READY; the round-key file is complete and `rk_out` is meaningful.
- `rk_idx`  input  4  decryption-order round-key index, 0..14; 15 is out of range.
- `rk_out`  output  128  registered round key for `rk_idx` from the previous cycle.

## Operation
- Storage: 15×128 array `e[0..14]`, kept in encryption order.
  - `e0 = key[255:128]`, `e1 = key[127:0]`.
  - Expansion step k (0..6) produces `X_k = key_expansion_256(prev, rcon_k)`, with `prev = key` for k=0 and `X_{k-1}` otherwise.
  - `e[2k+2] = X_k[255:128]`; `e[2k+3] = X_k[127:0]` for k<6. `X_6[127:0]` is discarded.
- rcon: 32-bit register, loaded with 32'h01000000 on key acceptance and shifted left by 1 after each step: 01,02,04,08,10,20,40 in the top byte.
- Working register `w` (256 bits) holds `prev`; it is loaded with `key` on acceptance and with `X_k` after each step.
- Read mapping: `rk_out <= (keys_valid && rk_idx <= 14) ? e[14 - rk_idx] : 128'h0`.
  - idx 0 = final encryption key; idx 13 = `key[127:0]`; idx 14 = `key[255:128]`.
- State machine:
  - IDLE → EXPAND on handshake: capture `key` into `w`, write `e0` and `e1`, set step counter to 0 and rcon to 01.
  - EXPAND: each cycle, compute `X_k` from `w`, write the array entries, update `w`, increment the counter and shift rcon. After step 6 → READY.
  - READY → EXPAND on a new handshake: same actions as from IDLE, and `keys_valid` drops the next cycle.
  - READY holds indefinitely otherwise; the stored keys persist.
- `key_valid` during EXPAND is ignored. `key_ready` is low, so no key is captured and expansion continues undisturbed.

## Timing
- Reset values: `key_ready`=1, `keys_valid`=0, `rk_out`=0, state IDLE, counter 0, rcon 32'h01000000, `w`=0, array all zero.
- Reset asserted mid-EXPAND or in READY returns to IDLE immediately (asynchronously). Any partial expansion is lost.
- Handshake at edge T0. Steps 0..6 complete at edges T1..T7, and `keys_valid`=1 from just after T7.
  - Load-to-valid latency: 7 cycles.
  - `key_ready` is low after T0 and high again after T7.
- Read latency: 1 cycle. `rk_idx` sampled at edge T gives `rk_out` stable after T.
  - Back-to-back indices stream one key per cycle.
- A read issued on the same cycle as a new handshake in READY still returns the old key. From the next edge, `rk_out` is 0 until the new expansion completes.
- Out-of-range index 15 → `rk_out` = 0 (with `keys_valid` still high).

## Test plan
- Reset → `key_ready`=1, `keys_valid`=0, `rk_out`=0. Read idx 0..15 → all 0.
- Load key 00010203…1e1f; count cycles → `keys_valid` rises exactly 7 cycles after the handshake.
  - Then idx0 = 24fc79ccbf0979e9371ac23c6d68de36, idx13 = 101112131415161718191a1b1c1d1e1f, idx14 = 000102030405060708090a0b0c0d0e0f.
- Load key 603deb1015ca71be2b73aef0857d7781 1f352c073b6108d72d9810a30914dff4 → idx0 = fe4890d1e6188d0b046df344706c631e.
  - Full idx0..14 sweep matches a reference model and the existing combinational decryptor's keys.
- Hold `key_valid`=1 with a different key throughout EXPAND → it is not accepted.
  - The first key's schedule is intact, and the second handshake occurs only after READY.
- Assert `rst` at step 3 of expansion → immediate IDLE, all outputs at reset values. Re-loading the same key yields the correct schedule.
- In READY, read idx 15 → 0. Reload key A then key B back-to-back → `keys_valid` drops one cycle after the second handshake, and key B's schedule is served 7 cycles later.

Source files
------------

// File: rtl/dec256_key_sched_if.sv
// rtl/dec256_key_sched_if.sv - key load handshake and round-key read port bundle
//
// Purpose: groups the cipher-key handshake and the round-key read port of
//          dec256_key_sched into one bundle.
// Signals:
//   key        [255:0] cipher key offered by the master
//   key_valid          master offers a key
//   key_ready          scheduler can accept a key
//   keys_valid         round-key file complete, rk_out meaningful
//   rk_idx     [3:0]   decryption-order round-key index (0..14, 15 out of range)
//   rk_out     [127:0] registered round key for the previous cycle's rk_idx
interface dec256_key_sched_if;
    logic [255:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    modport master (
        output key, key_valid, rk_idx,
        input  key_ready, keys_valid, rk_out
    );

    modport slave (
        input  key, key_valid, rk_idx,
        output key_ready, keys_valid, rk_out
    );
endinterface

// File: rtl/dec256_key_sched.sv
// rtl/dec256_key_sched.sv - iterative AES-256 round-key scheduler for decryption
//
// Purpose: accepts a 256-bit key, expands it with one shared expansion stage
//          (one step per clock, 7 steps), stores the 15 round keys and serves
//          them through a registered read port in decryption order.
// Ports:
//   clk   input   clock, rising edge
//   rst   input   asynchronous active-high reset
//   bus   slave   dec256_key_sched_if (key handshake + round-key read port)

// One AES-256 expansion step: eight new words from the previous eight.
// Ports: prev_i [255:0] previous 8 words (w0 in the top bits), rcon_i [31:0]
//        round constant in the top byte, next_o [255:0] next 8 words.
module key_expansion_256 (
    input  logic [255:0] prev_i,
    input  logic [31:0]  rcon_i,
    output logic [255:0] next_o
);
    // Byte b of the S-box sits at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // 255 - b is ~b for an 8-bit value
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w_in [8];
    logic [31:0] w_out [8];
    logic [31:0] t_rot;
    logic [31:0] t_sub;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_in[i] = prev_i[255 - 32*i -: 32];
        end
        // First half uses RotWord/SubWord/rcon on the last word of prev
        t_rot    = sub_word({w_in[7][23:0], w_in[7][31:24]}) ^ rcon_i;
        w_out[0] = w_in[0] ^ t_rot;
        w_out[1] = w_in[1] ^ w_out[0];
        w_out[2] = w_in[2] ^ w_out[1];
        w_out[3] = w_in[3] ^ w_out[2];
        // AES-256 adds a plain SubWord in the middle of each 8-word block
        t_sub    = sub_word(w_out[3]);
        w_out[4] = w_in[4] ^ t_sub;
        w_out[5] = w_in[5] ^ w_out[4];
        w_out[6] = w_in[6] ^ w_out[5];
        w_out[7] = w_in[7] ^ w_out[6];
        next_o   = {w_out[0], w_out[1], w_out[2], w_out[3],
                    w_out[4], w_out[5], w_out[6], w_out[7]};
    end
endmodule

module dec256_key_sched (
    input  logic               clk,
    input  logic               rst,
    dec256_key_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t         state_q;
    logic [2:0]     cnt_q;
    logic [31:0]    rcon_q;
    logic [255:0]   w_q;
    logic [127:0]   e_q [15];
    logic           key_ready_q;
    logic           keys_valid_q;
    logic [127:0]   rk_out_q;

    logic [255:0]   x_d;
    logic [3:0]     wr_idx;
    logic           accept;

    key_expansion_256 u_kexp (
        .prev_i (w_q),
        .rcon_i (rcon_q),
        .next_o (x_d)
    );

    // Step k writes e[2k+2] and e[2k+3]
    assign wr_idx = {cnt_q, 1'b0} + 4'd2;
    // key_ready_q is low exactly in EXPAND, so it gates the handshake
    assign accept = bus.key_valid && key_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            rcon_q       <= 32'h0100_0000;
            w_q          <= '0;
            key_ready_q  <= 1'b1;
            keys_valid_q <= 1'b0;
            rk_out_q     <= '0;
            for (int i = 0; i < 15; i++) begin
                e_q[i] <= '0;
            end
        end else begin
            // Read port uses the pre-edge keys_valid, so a read on the
            // reload cycle still returns the old schedule.
            if (keys_valid_q && bus.rk_idx <= 4'd14) begin
                rk_out_q <= e_q[4'd14 - bus.rk_idx];
            end else begin
                rk_out_q <= '0;
            end

            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        state_q      <= ST_EXPAND;
                        w_q          <= bus.key;
                        e_q[0]       <= bus.key[255:128];
                        e_q[1]       <= bus.key[127:0];
                        cnt_q        <= 3'd0;
                        rcon_q       <= 32'h0100_0000;
                        key_ready_q  <= 1'b0;
                        keys_valid_q <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    e_q[wr_idx] <= x_d[255:128];
                    // The last step's lower half would be e[15], which does not exist
                    if (cnt_q != 3'd6) begin
                        e_q[wr_idx + 4'd1] <= x_d[127:0];
                    end
                    w_q    <= x_d;
                    cnt_q  <= cnt_q + 3'd1;
                    rcon_q <= {rcon_q[30:0], 1'b0};
                    if (cnt_q == 3'd6) begin
                        state_q      <= ST_READY;
                        key_ready_q  <= 1'b1;
                        keys_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    key_ready_q  <= 1'b1;
                    keys_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_ready  = key_ready_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.rk_out     = rk_out_q;
endmodule

// File: tb/tb_dec256_key_sched.sv
// tb/tb_dec256_key_sched.sv - directed self-checking bench for dec256_key_sched
module tb_dec256_key_sched;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dec256_key_sched_if bus ();

    dec256_key_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // Reference S-box built from GF(2^8) inversion plus the affine map
    logic [7:0]   sb [256];
    logic [127:0] rk_enc [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Word-by-word key expansion into rk_enc (encryption order)
    task automatic expand_model(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)
                t = subw({t[23:0], t[31:24]}) ^ ({24'h0, 8'h01 << (i/8 - 1)} << 24);
            else if (i % 8 == 4)
                t = subw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk_enc[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rk_idx presented now, rk_out checked after the next edge
    task automatic read_chk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        bus.rk_idx = idx;
        step();
        chk($sformatf("%s[%0d]", tag, idx), bus.rk_out, exp);
    endtask

    // Counts edges after the handshake until keys_valid rises (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (bus.keys_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic load(input string tag, input logic [255:0] k);
        int lat;
        bus.key       = k;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        chk({tag, "_ready_low"}, 128'(bus.key_ready), 128'd0);
        wait_valid(lat);
        chk({tag, "_latency"}, 128'(lat), 128'd7);
        chk({tag, "_ready_high"}, 128'(bus.key_ready), 128'd1);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 15; i++) read_chk(tag, 4'(i), rk_enc[14 - i]);
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        build_sbox();

        bus.key       = '0;
        bus.key_valid = 1'b0;
        bus.rk_idx    = 4'd0;
        rst           = 1'b1;
        step();
        step();
        chk("rst_key_ready", 128'(bus.key_ready), 128'd1);
        chk("rst_keys_valid", 128'(bus.keys_valid), 128'd0);
        chk("rst_rk_out", bus.rk_out, 128'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) read_chk("idle_read", 4'(i), 128'd0);

        // Key 1: FIPS-197 AES-256 example key
        expand_model(KEY1);
        load("k1", KEY1);
        read_chk("k1_idx0_const", 4'd0, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_chk("k1_idx13_const", 4'd13, 128'h101112131415161718191a1b1c1d1e1f);
        read_chk("k1_idx14_const", 4'd14, 128'h000102030405060708090a0b0c0d0e0f);
        sweep("k1_sweep");

        // Key 2: FIPS-197 appendix A.3 key
        expand_model(KEY2);
        load("k2", KEY2);
        read_chk("k2_idx0_const", 4'd0, 128'hfe4890d1e6188d0b046df344706c631e);
        sweep("k2_sweep");
        read_chk("k2_idx15", 4'd15, 128'd0);
        chk("k2_idx15_valid", 128'(bus.keys_valid), 128'd1);

        // Key 1 accepted, then key 2 held valid all through EXPAND
        expand_model(KEY1);
        bus.key       = KEY1;
        bus.key_valid = 1'b1;
        step();
        bus.key       = KEY2;
        wait_valid(lat);
        chk("hold_latency", 128'(lat), 128'd7);
        // Next edge is key 2's handshake; the read on it returns key 1's data
        bus.rk_idx = 4'd13;
        step();
        bus.key_valid = 1'b0;
        chk("hold_old_read", bus.rk_out, rk_enc[1]);
        chk("hold_valid_drop", 128'(bus.keys_valid), 128'd0);
        chk("hold_ready_low", 128'(bus.key_ready), 128'd0);
        read_chk("reload_zero", 4'd0, 128'd0);
        expand_model(KEY2);
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            step();
            if (bus.keys_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("reload_latency", 128'(lat), 128'd7);
        sweep("k2b_sweep");

        // Reset in the middle of expansion
        expand_model(KEY1);
        bus.key       = KEY1;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_key_ready", 128'(bus.key_ready), 128'd1);
        chk("midrst_keys_valid", 128'(bus.keys_valid), 128'd0);
        chk("midrst_rk_out", bus.rk_out, 128'd0);
        step();
        rst = 1'b0;
        read_chk("midrst_read", 4'd0, 128'd0);
        load("k1r", KEY1);
        sweep("k1r_sweep");
        read_chk("k1r_idx15", 4'd15, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
